// File: rtl/dm_arbiter_pkg.sv
// Shared definitions for the dual-port memory arbiter: ownership state
// encoding, bus widths and the per-port request bundle.
package dm_arbiter_pkg;

   localparam int DM_ADDR_W = 10;
   localparam int DM_DATA_W = 32;

   // Ownership state: nobody owns the memory, or port 0 / port 1 holds it.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } dm_state_e;

   // Everything one port presents in a cycle, bundled so the memory mux
   // can select a whole port in one step.
   typedef struct packed {
      logic                 req;
      logic                 lock;
      logic                 we;
      logic [DM_ADDR_W-1:0] addr;
      logic [DM_DATA_W-1:0] wdata;
   } dm_port_s;

   // Ownership state that corresponds to a given port index.
   function automatic dm_state_e own_state(input logic port);
      return port ? OWN1 : OWN0;
   endfunction

endpackage

// File: rtl/dm_arb_pick.sv
// Combinational grant selection for the dual-port memory arbiter.
// An owning port is served whenever it asks and locks the other port out;
// with no owner a single requester wins outright and a tie goes to the port
// opposite the last grant. Build option DM_ARB_FIXED_PRIO_EN makes every
// tie favour port 0 instead, leaving the round-robin pointer unused.
module dm_arb_pick
   import dm_arbiter_pkg::*;
(
   input  logic [1:0] req_i,
   input  dm_state_e  state_i,
   input  logic       rr_last_i,
   output logic [1:0] gnt_o
);

`ifdef DM_ARB_FIXED_PRIO_EN
   // The pointer is kept by the parent but plays no part in a fixed-priority tie.
   logic unused_rr_last;
   assign unused_rr_last = rr_last_i;
`endif

   // One-hot (or empty) grant from ownership and the current requests.
   always_comb begin
      // NOTE: default every output first so no path leaves gnt_o unassigned,
      // which would otherwise infer a latch.
      gnt_o = 2'b00;
      case (state_i)
         OWN0:    gnt_o[0] = req_i[0];
         OWN1:    gnt_o[1] = req_i[1];
         default: begin
            if (req_i == 2'b11) begin
`ifdef DM_ARB_FIXED_PRIO_EN
               gnt_o = 2'b01;
`else
               gnt_o = rr_last_i ? 2'b01 : 2'b10;
`endif
            end else begin
               gnt_o = req_i;
            end
         end
      endcase
   end

endmodule

// File: rtl/dm_arbiter.sv
// Two-port arbiter in front of a single asynchronous-read word memory.
// Ports may lock ownership across consecutive accesses; after LOCK_MAX
// consecutive grants a waiting peer forces ownership back to IDLE.
// Reads return registered data one cycle after the grant.
// Build option: DM_ARB_FIXED_PRIO_EN (ties always favour port 0).
module dm_arbiter
   import dm_arbiter_pkg::*;
#(
   parameter int unsigned LOCK_MAX = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 p0_req,
   input  logic                 p0_lock,
   input  logic                 p0_we,
   input  logic [DM_ADDR_W-1:0] p0_addr,
   input  logic [DM_DATA_W-1:0] p0_wdata,
   input  logic                 p1_req,
   input  logic                 p1_lock,
   input  logic                 p1_we,
   input  logic [DM_ADDR_W-1:0] p1_addr,
   input  logic [DM_DATA_W-1:0] p1_wdata,
   output logic                 p0_gnt,
   output logic                 p1_gnt,
   output logic                 p0_rvalid,
   output logic                 p1_rvalid,
   output logic [DM_DATA_W-1:0] p0_rdata,
   output logic [DM_DATA_W-1:0] p1_rdata,
   output logic [DM_ADDR_W-1:0] mem_addr,
   output logic [DM_DATA_W-1:0] mem_din,
   output logic                 mem_we,
   input  logic [DM_DATA_W-1:0] mem_dout
);

   localparam logic [7:0] LOCK_MAX_C = 8'(LOCK_MAX);

   dm_state_e            state_q, state_d;
   logic                 rr_last_q, rr_last_d;
   logic [7:0]           lock_cnt_q, lock_cnt_d;
   logic [1:0]           rvalid_q;
   logic [DM_DATA_W-1:0] rdata0_q, rdata1_q;

   dm_port_s   prt0, prt1, sel;
   logic [1:0] pick_gnt;
   logic [1:0] gnt;
   logic       grant_any;
   logic       gnt_port;
   logic       other_req;
   logic [7:0] run_cnt;

   assign prt0 = '{req: p0_req, lock: p0_lock, we: p0_we, addr: p0_addr, wdata: p0_wdata};
   assign prt1 = '{req: p1_req, lock: p1_lock, we: p1_we, addr: p1_addr, wdata: p1_wdata};

   dm_arb_pick u_pick (
      .req_i     ({p1_req, p0_req}),
      .state_i   (state_q),
      .rr_last_i (rr_last_q),
      .gnt_o     (pick_gnt)
   );

   // Reset suppresses every grant, and with it any memory write.
   assign gnt       = rst ? 2'b00 : pick_gnt;
   assign grant_any = |gnt;
   assign gnt_port  = gnt[1];
   assign sel       = gnt_port ? prt1 : prt0;
   assign other_req = gnt_port ? p0_req : p1_req;

   assign p0_gnt    = gnt[0];
   assign p1_gnt    = gnt[1];
   assign p0_rvalid = rvalid_q[0];
   assign p1_rvalid = rvalid_q[1];
   assign p0_rdata  = rdata0_q;
   assign p1_rdata  = rdata1_q;

   // Memory mux: the granted port drives the memory, an idle cycle drives zeros.
   always_comb begin
      mem_addr = '0;
      mem_din  = '0;
      mem_we   = 1'b0;
      if (grant_any) begin
         mem_addr = sel.addr;
         mem_din  = sel.wdata;
         mem_we   = sel.we;
      end
   end

   // Next ownership, round-robin pointer and consecutive-grant count.
   always_comb begin
      state_d    = state_q;
      rr_last_d  = rr_last_q;
      lock_cnt_d = lock_cnt_q;
      run_cnt    = 8'd1;
      if (!grant_any) begin
         state_d    = IDLE;
         lock_cnt_d = 8'd0;
      end else begin
         rr_last_d = gnt_port;
         // The run continues only if this port already owned the memory;
         // it saturates at LOCK_MAX so a long uncontested lock cannot wrap.
         if (state_q == own_state(gnt_port)) begin
            run_cnt = (lock_cnt_q >= LOCK_MAX_C) ? LOCK_MAX_C : lock_cnt_q + 8'd1;
         end
         if (sel.lock && !((run_cnt == LOCK_MAX_C) && other_req)) begin
            state_d    = own_state(gnt_port);
            lock_cnt_d = run_cnt;
         end else begin
            state_d    = IDLE;
            lock_cnt_d = 8'd0;
         end
      end
   end

   // Arbitration FSM registers.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples its pre-edge value regardless of statement order.
      if (rst) begin
         state_q    <= IDLE;
         rr_last_q  <= 1'b1;
         lock_cnt_q <= 8'd0;
      end else begin
         state_q    <= state_d;
         rr_last_q  <= rr_last_d;
         lock_cnt_q <= lock_cnt_d;
      end
   end

   // Read return path: capture memory data at the end of a granted read.
   always_ff @(posedge clk) begin
      if (rst) begin
         rvalid_q <= 2'b00;
         rdata0_q <= '0;
         rdata1_q <= '0;
      end else begin
         rvalid_q <= gnt & {~p1_we, ~p0_we};
         if (gnt[0] && !p0_we) rdata0_q <= mem_dout;
         if (gnt[1] && !p1_we) rdata1_q <= mem_dout;
      end
   end

endmodule

// File: tb/tb_dm_arbiter.sv
// Randomised and directed checking of dm_arbiter against a behavioural
// model of ownership, round-robin and the attached word memory.
module tb_dm_arbiter;

   localparam int LOCK_MAX = 8;
`ifdef DM_ARB_FIXED_PRIO_EN
   localparam bit FIXED = 1'b1;
`else
   localparam bit FIXED = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        p0_req, p0_lock, p0_we, p1_req, p1_lock, p1_we;
   logic [9:0]  p0_addr, p1_addr, mem_addr;
   logic [31:0] p0_wdata, p1_wdata, mem_din, mem_dout;
   logic        p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, mem_we;
   logic [31:0] p0_rdata, p1_rdata;

   dm_arbiter #(.LOCK_MAX(LOCK_MAX)) dut (
      .clk(clk), .rst(rst),
      .p0_req(p0_req), .p0_lock(p0_lock), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
      .p1_req(p1_req), .p1_lock(p1_lock), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
      .p0_gnt(p0_gnt), .p1_gnt(p1_gnt), .p0_rvalid(p0_rvalid), .p1_rvalid(p1_rvalid),
      .p0_rdata(p0_rdata), .p1_rdata(p1_rdata),
      .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we), .mem_dout(mem_dout)
   );

   // Attached memory: asynchronous read, write on posedge.
   logic [31:0] mem [1024];
   always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_din;
   assign mem_dout = mem[mem_addr];

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s (cycle %0d): got %0h, expected %0h", tag, cyc, got, exp);
      end
   endtask

   // Stimulus for the coming cycle.
   bit          s_rst;
   bit          s_req [2];
   bit          s_lock[2];
   bit          s_we  [2];
   logic [9:0]  s_addr[2];
   logic [31:0] s_wdata[2];

   // Reference model: who owns the memory, how many grants in a row it has
   // had, the last winner, expected read returns and memory contents.
   int          m_owner = -1;
   int          m_run   = 0;
   int          m_last  = 1;
   bit          m_rv[2];
   logic [31:0] m_rd[2];
   logic [31:0] ref_mem[1024];

   function automatic int winner();
      if (s_rst) return -1;
      if (m_owner >= 0) return s_req[m_owner] ? m_owner : -1;
      if (s_req[0] && s_req[1]) return FIXED ? 0 : 1 - m_last;
      if (s_req[0]) return 0;
      if (s_req[1]) return 1;
      return -1;
   endfunction

   task automatic idle_inputs();
      for (int p = 0; p < 2; p++) begin
         s_req[p] = 0; s_lock[p] = 0; s_we[p] = 0; s_addr[p] = '0; s_wdata[p] = '0;
      end
      s_rst = 0;
   endtask

   task automatic set_port(input int p, input bit req, input bit lock, input bit we,
                           input logic [9:0] addr, input logic [31:0] wdata);
      s_req[p] = req; s_lock[p] = lock; s_we[p] = we; s_addr[p] = addr; s_wdata[p] = wdata;
   endtask

   // Apply one cycle of stimulus, compare all outputs, advance the model.
   // Returns mid-cycle so callers can add targeted checks.
   task automatic run_cycle();
      int w;
      int run;
      @(negedge clk);
      cyc++;
      rst = s_rst;
      p0_req = s_req[0]; p0_lock = s_lock[0]; p0_we = s_we[0]; p0_addr = s_addr[0]; p0_wdata = s_wdata[0];
      p1_req = s_req[1]; p1_lock = s_lock[1]; p1_we = s_we[1]; p1_addr = s_addr[1]; p1_wdata = s_wdata[1];
      #1;
      w = winner();
      check("gnt0",    p0_gnt,    32'(w == 0));
      check("gnt1",    p1_gnt,    32'(w == 1));
      check("mem_we",  mem_we,    32'(w >= 0 && s_we[w]));
      check("mem_addr", mem_addr, (w >= 0) ? 32'(s_addr[w]) : 32'd0);
      check("mem_din", mem_din,   (w >= 0) ? s_wdata[w] : 32'd0);
      check("rvalid0", p0_rvalid, 32'(m_rv[0]));
      check("rvalid1", p1_rvalid, 32'(m_rv[1]));
      check("rdata0",  p0_rdata,  m_rd[0]);
      check("rdata1",  p1_rdata,  m_rd[1]);
      m_rv[0] = 0; m_rv[1] = 0;
      if (s_rst) begin
         m_owner = -1; m_run = 0; m_last = 1; m_rd[0] = '0; m_rd[1] = '0;
      end else if (w < 0) begin
         m_owner = -1; m_run = 0;
      end else begin
         if (s_we[w]) ref_mem[s_addr[w]] = s_wdata[w];
         else begin
            m_rv[w] = 1;
            m_rd[w] = ref_mem[s_addr[w]];
         end
         m_last = w;
         run = (m_owner == w) ? m_run + 1 : 1;
         if (run > LOCK_MAX) run = LOCK_MAX;
         if (s_lock[w] && !(run == LOCK_MAX && s_req[1 - w])) begin
            m_owner = w; m_run = run;
         end else begin
            m_owner = -1; m_run = 0;
         end
      end
   endtask

   task automatic do_reset();
      idle_inputs();
      s_rst = 1;
      run_cycle();
      s_rst = 0;
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) begin
         mem[i] = '0;
         ref_mem[i] = '0;
      end
      m_rv[0] = 0; m_rv[1] = 0; m_rd[0] = '0; m_rd[1] = '0;
      idle_inputs();
      rst = 1;
      p0_req = 0; p0_lock = 0; p0_we = 0; p0_addr = '0; p0_wdata = '0;
      p1_req = 0; p1_lock = 0; p1_we = 0; p1_addr = '0; p1_wdata = '0;
      repeat (2) @(posedge clk);

      // Reset state: nothing granted, no read data pending.
      run_cycle();
      check("reset_rvalid0", p0_rvalid, 0);
      check("reset_rdata1", p1_rdata, 0);

      // First tie goes to port 0, the next one to port 1.
      do_reset();
      set_port(0, 1, 0, 0, 10'd0, 0);
      set_port(1, 1, 0, 0, 10'd1, 0);
      run_cycle();
      check("tie_first_p0", p0_gnt, 1);
      run_cycle();
      check("tie_second_p1", p1_gnt, FIXED ? 0 : 1);

      // Write by port 1 visible to a following read by port 0.
      idle_inputs();
      set_port(1, 1, 0, 1, 10'h005, 32'hDEADBEEF);
      run_cycle();
      idle_inputs();
      set_port(0, 1, 0, 0, 10'h005, 0);
      run_cycle();
      check("wr_rd_gnt", p0_gnt, 1);
      idle_inputs();
      run_cycle();
      check("wr_rd_rvalid", p0_rvalid, 1);
      check("wr_rd_data", p0_rdata, 32'hDEADBEEF);
      run_cycle();
      check("rvalid_one_cycle", p0_rvalid, 0);
      check("rdata_holds", p0_rdata, 32'hDEADBEEF);

      // Locked port 0 keeps the memory for LOCK_MAX grants, then must yield.
      do_reset();
      set_port(0, 1, 1, 0, 10'd7, 0);
      set_port(1, 1, 0, 0, 10'd8, 0);
      for (int i = 0; i < LOCK_MAX; i++) begin
         run_cycle();
         check("lock_hold_p0", p0_gnt, 1);
      end
      run_cycle();
      check("lock_rotate_p1", p1_gnt, FIXED ? 0 : 1);

      // Reset in the middle of a locked burst drops ownership.
      do_reset();
      set_port(0, 1, 1, 0, 10'd3, 0);
      set_port(1, 1, 0, 0, 10'd4, 0);
      repeat (3) run_cycle();
      s_rst = 1;
      run_cycle();
      check("rst_mid_gnt0", p0_gnt, 0);
      check("rst_mid_gnt1", p1_gnt, 0);
      check("rst_mid_we", mem_we, 0);
      s_rst = 0;
      s_lock[0] = 0;
      run_cycle();
      check("rst_after_rvalid", p0_rvalid, 0);
      check("rst_after_tie_p0", p0_gnt, 1);

      // Back-to-back reads by port 1 return data every cycle.
      do_reset();
      for (int a = 0; a < 4; a++) begin
         set_port(1, 1, 0, 1, 10'(a), 32'(10 + a));
         run_cycle();
      end
      for (int a = 0; a < 4; a++) begin
         set_port(1, 1, 0, 0, 10'(a), 0);
         run_cycle();
         if (a > 0) begin
            check("b2b_rvalid", p1_rvalid, 1);
            check("b2b_rdata", p1_rdata, 32'(10 + a - 1));
         end
      end
      idle_inputs();
      run_cycle();
      check("b2b_last_rvalid", p1_rvalid, 1);
      check("b2b_last_rdata", p1_rdata, 32'd13);

      // Both requesting without lock for four cycles.
      do_reset();
      set_port(0, 1, 0, 0, 10'd0, 0);
      set_port(1, 1, 0, 0, 10'd1, 0);
      for (int i = 0; i < 4; i++) begin
         run_cycle();
         check("both4_p0", p0_gnt, FIXED ? 1 : 32'(i % 2 == 0));
         check("both4_p1", p1_gnt, FIXED ? 0 : 32'(i % 2 == 1));
      end

      // Randomised traffic over a small address window to force collisions.
      for (int i = 0; i < 3000; i++) begin
         s_rst = ($urandom_range(0, 63) == 0);
         for (int p = 0; p < 2; p++) begin
            s_req[p]   = ($urandom_range(0, 9) < 7);
            s_lock[p]  = ($urandom_range(0, 1) == 1);
            s_we[p]    = ($urandom_range(0, 9) < 4);
            s_addr[p]  = 10'($urandom_range(0, 7));
            s_wdata[p] = $urandom;
         end
         run_cycle();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/dm_arbiter.md
DM_ARBITER -- requirements
Module: dm_arbiter

Interface
REQ-001 Parameter: LOCK_MAX, default 8, maximum consecutive locked grants to one port before forced rotation (range 1..255).
REQ-002 Port: clk  input  1  single clock; all state updates on posedge clk.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: p0_req / p1_req  input  1  port n requests one memory access this cycle.
REQ-005 Port: p0_lock / p1_lock  input  1  port n asks to keep ownership after this access.
REQ-006 Port: p0_we / p1_we  input  1  access is a write.
REQ-007 Port: p0_addr / p1_addr  input  10  word address [11:2].
REQ-008 Port: p0_wdata / p1_wdata  input  32  write data.
REQ-009 Port: p0_gnt / p1_gnt  output  1  access accepted this cycle (combinational).
REQ-010 Port: p0_rvalid / p1_rvalid  output  1  read data valid; registered.
REQ-011 Port: p0_rdata / p1_rdata  output  32  registered read data.
REQ-012 Port: mem_addr  output  10; mem_din  output  32; mem_we  output  1; mem_dout  input  32 (asynchronous-read word memory, posedge write).

Function
REQ-013 States: IDLE, OWN0, OWN1; at most one gnt SHALL be high in any cycle.
REQ-014 IDLE, one req: grant that port; both req: grant port opposite rr_last (round-robin pointer).
REQ-015 OWNn: port n SHALL be granted whenever it requests; other port SHALL NOT be granted while OWNn held.
REQ-016 Granted with lock=1 -> next state OWNn; lock=0 or req=0 while OWNn -> IDLE.
REQ-017 lock_cnt SHALL count consecutive grants in OWNn; when lock_cnt reaches LOCK_MAX and the other port requests, next state IDLE with rr_last=n (forced rotation), lock ignored.
REQ-018 rr_last SHALL update to the granted port on every grant.
REQ-019 Memory mux: mem_addr/mem_din from granted port; mem_we = gnt & we of that port; no grant -> mem_we=0, mem_addr=0, mem_din=0.
REQ-020 Write completes at the posedge ending the grant cycle; no rvalid for writes.
REQ-021 Read granted in cycle T: pn_rdata=mem_dout captured at end of T, pn_rvalid=1 in T+1 only (1-cycle latency); rdata holds until next read of that port.
REQ-022 Back-to-back reads by one port SHALL give rvalid every cycle (full throughput).
REQ-023 Write and read to same address by different ports in consecutive cycles: read SHALL return the new data.

Reset
REQ-024 rst high at posedge: state=IDLE, rr_last=1 (port 0 wins first tie), lock_cnt=0, rvalid=0, rdata=0; gnt and mem_we SHALL be 0 while rst high.
REQ-025 Reset during locked ownership SHALL drop ownership; pending rvalid SHALL be cleared.

Configuration
REQ-026 Macro DM_ARB_FIXED_PRIO_EN defined: tie and IDLE arbitration always favour port 0, rr_last unused; locking and LOCK_MAX rotation still apply.
REQ-027 Macro undefined: round-robin per REQ-014.

Structure
REQ-028 Shared package SHALL hold state encoding (IDLE=2'd0, OWN0=2'd1, OWN1=2'd2), DM_ADDR_W=10, DM_DATA_W=32.
REQ-029 One sub-module dm_arb_pick (combinational grant select from reqs, state, rr_last) is natural; rest flat.

Verification
REQ-030 Reset, then p0_req and p1_req reads same cycle -> p0_gnt=1; next cycle both again -> p1_gnt=1.
REQ-031 p1 writes 0xDEADBEEF to addr 0x05 cycle T; p0 reads 0x05 at T+1 -> p0_rvalid=1 at T+2, p0_rdata=0xDEADBEEF.
REQ-032 p0 lock=1 requesting continuously, p1 requesting, LOCK_MAX=8 -> p0 granted 8 cycles, then p1 granted.
REQ-033 p0 locked, rst asserted mid-burst -> next cycle gnt=0, rvalid=0; after release p0 wins tie.
REQ-034 DM_ARB_FIXED_PRIO_EN defined, both request 4 cycles without lock -> p0_gnt=1 all 4 cycles, p1_gnt=0.
REQ-035 p1 back-to-back reads addr 0..3 holding 10,11,12,13 -> p1_rvalid high 4 consecutive cycles, data 10,11,12,13.
